// File: rtl/alu_step_ctrl.sv
// Operand-entry sequencer for the board ALU: debounced ENTER/CLEAR keys step through
// operand A, operand B and opcode entry, then capture the ALU result and flags for display.
module alu_step_ctrl #(
    parameter int DEBOUNCE_CYCLES = 50000
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic [17:0] SW,
    input  logic [3:0]  KEY,
    output logic [31:0] portA,
    output logic [31:0] portB,
    output logic [3:0]  aluop,
    input  logic [31:0] outPort,
    input  logic        negF,
    input  logic        zerF,
    input  logic        oveF,
    output logic [31:0] disp_val,
    output logic [2:0]  flags,
    output logic [2:0]  state
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] DB_LIMIT = CW'(DEBOUNCE_CYCLES);

    typedef enum logic [2:0] {
        S_LOAD_A  = 3'd0,
        S_LOAD_B  = 3'd1,
        S_LOAD_OP = 3'd2,
        S_EXEC    = 3'd3,
        S_RESULT  = 3'd4
    } state_t;

    logic [16:0]   sw_meta_q;
    logic [16:0]   sw_sync_q;
    logic [1:0]    key_meta_q;
    logic [1:0]    key_sync_q;
    logic [1:0]    key_db_q;
    logic [1:0]    key_db_d;
    logic [1:0]    key_prev_q;
    logic [CW-1:0] cnt_q [2];
    logic [CW-1:0] cnt_d [2];

    logic          enter_s;
    logic          clear_s;
    logic [31:0]   operand_s;
    logic          unused_s;

    state_t        state_q;
    state_t        state_d;
    logic [31:0]   rega_q;
    logic [31:0]   rega_d;
    logic [31:0]   regb_q;
    logic [31:0]   regb_d;
    logic [3:0]    op_q;
    logic [3:0]    op_d;
    logic [31:0]   result_q;
    logic [31:0]   result_d;
    logic [2:0]    flags_q;
    logic [2:0]    flags_d;

    assign unused_s  = ^{KEY[3:2], SW[17]};
    assign operand_s = {{16{sw_sync_q[15]}}, sw_sync_q[15:0]};
    // A press is a debounced high-to-low transition; releases are ignored.
    assign enter_s   = key_prev_q[0] & ~key_db_q[0];
    assign clear_s   = key_prev_q[1] & ~key_db_q[1];

    // Debounce counters: count while the synchronized level disagrees with the accepted one.
    always_comb begin
        for (int i = 0; i < 2; i++) begin
            key_db_d[i] = key_db_q[i];
            cnt_d[i]    = '0;
            if (key_sync_q[i] != key_db_q[i]) begin
                if (cnt_q[i] == DB_LIMIT) begin
                    key_db_d[i] = key_sync_q[i];
                    cnt_d[i]    = '0;
                end else begin
                    cnt_d[i]    = cnt_q[i] + CW'(1);
                end
            end else begin
                cnt_d[i] = '0;
            end
        end
    end

    // Input synchronizers, debounced levels and edge-detect history.
    always_ff @(posedge CLK) begin
        if (RST) begin
            sw_meta_q  <= 17'd0;
            sw_sync_q  <= 17'd0;
            key_meta_q <= 2'b11;
            key_sync_q <= 2'b11;
            key_db_q   <= 2'b11;
            key_prev_q <= 2'b11;
            for (int i = 0; i < 2; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            sw_meta_q  <= SW[16:0];
            sw_sync_q  <= sw_meta_q;
            key_meta_q <= KEY[1:0];
            key_sync_q <= key_meta_q;
            key_db_q   <= key_db_d;
            key_prev_q <= key_db_q;
            for (int i = 0; i < 2; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    // Sequencer next state and register captures; CLEAR overrides everything.
    always_comb begin
        state_d  = state_q;
        rega_d   = rega_q;
        regb_d   = regb_q;
        op_d     = op_q;
        result_d = result_q;
        flags_d  = flags_q;
        if (clear_s) begin
            state_d  = S_LOAD_A;
            rega_d   = 32'd0;
            regb_d   = 32'd0;
            op_d     = 4'd0;
            result_d = 32'd0;
            flags_d  = 3'd0;
        end else begin
            case (state_q)
                S_LOAD_A: begin
                    if (enter_s) begin
                        rega_d  = operand_s;
                        state_d = S_LOAD_B;
                    end else begin
                        state_d = S_LOAD_A;
                    end
                end
                S_LOAD_B: begin
                    if (enter_s) begin
                        regb_d  = operand_s;
                        state_d = S_LOAD_OP;
                    end else begin
                        state_d = S_LOAD_B;
                    end
                end
                S_LOAD_OP: begin
                    if (enter_s) begin
                        op_d    = sw_sync_q[3:0];
                        state_d = S_EXEC;
                    end else begin
                        state_d = S_LOAD_OP;
                    end
                end
                S_EXEC: begin
                    result_d = outPort;
                    flags_d  = {negF, zerF, oveF};
                    state_d  = S_RESULT;
                end
                S_RESULT: begin
                    if (enter_s) begin
                        if (sw_sync_q[16]) begin
                            rega_d  = result_q;
                            state_d = S_LOAD_B;
                        end else begin
                            state_d = S_LOAD_A;
                        end
                    end else begin
                        state_d = S_RESULT;
                    end
                end
                default: begin
                    state_d = S_LOAD_A;
                end
            endcase
        end
    end

    // Sequencer state and operand/result registers.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q  <= S_LOAD_A;
            rega_q   <= 32'd0;
            regb_q   <= 32'd0;
            op_q     <= 4'd0;
            result_q <= 32'd0;
            flags_q  <= 3'd0;
        end else begin
            state_q  <= state_d;
            rega_q   <= rega_d;
            regb_q   <= regb_d;
            op_q     <= op_d;
            result_q <= result_d;
            flags_q  <= flags_d;
        end
    end

    // Display source: the live entry value while loading, the stored result otherwise.
    always_comb begin
        disp_val = 32'd0;
        case (state_q)
            S_LOAD_A:  disp_val = operand_s;
            S_LOAD_B:  disp_val = operand_s;
            S_LOAD_OP: disp_val = {28'd0, sw_sync_q[3:0]};
            S_EXEC:    disp_val = result_q;
            S_RESULT:  disp_val = result_q;
            default:   disp_val = 32'd0;
        endcase
    end

    assign portA = rega_q;
    assign portB = regb_q;
    assign aluop = op_q;
    assign flags = flags_q;
    assign state = state_q;

endmodule

// File: tb/tb_alu_step_ctrl.sv
// Self-checking bench for alu_step_ctrl: directed scenarios plus randomized key/switch
// sessions compared against a press-level reference model and a small behavioural ALU.
module tb_alu_step_ctrl;

    localparam int DB = 4;

    logic        CLK = 1'b0;
    logic        RST;
    logic [17:0] SW;
    logic [3:0]  KEY;
    logic [31:0] portA, portB, outPort, disp_val;
    logic [3:0]  aluop;
    logic        negF, zerF, oveF;
    logic [2:0]  flags, state;

    int n_checks = 0;
    int n_pass   = 0;
    int exec_run = 0;
    int exec_last = 0;

    int          m_state;
    logic [31:0] m_a, m_b, m_res;
    logic [3:0]  m_op;
    logic [2:0]  m_fl;

    always #5 CLK = ~CLK;

    alu_step_ctrl #(.DEBOUNCE_CYCLES(DB)) dut (
        .CLK(CLK), .RST(RST), .SW(SW), .KEY(KEY),
        .portA(portA), .portB(portB), .aluop(aluop),
        .outPort(outPort), .negF(negF), .zerF(zerF), .oveF(oveF),
        .disp_val(disp_val), .flags(flags), .state(state)
    );

    // Behavioural ALU: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, others pass A. Returns {result, n, z, v}.
    function automatic logic [34:0] alu_f(input logic [31:0] a, input logic [31:0] b, input logic [3:0] op);
        logic [31:0] r;
        logic        v;
        r = 32'd0;
        v = 1'b0;
        case (op)
            4'd0: begin r = a + b; v = (a[31] == b[31]) && (r[31] != a[31]); end
            4'd1: begin r = a - b; v = (a[31] != b[31]) && (r[31] != a[31]); end
            4'd2: r = a & b;
            4'd3: r = a | b;
            4'd4: r = a ^ b;
            default: r = a;
        endcase
        return {r, r[31], (r == 32'd0), v};
    endfunction

    always_comb {outPort, negF, zerF, oveF} = alu_f(portA, portB, aluop);

    // Length of the most recent run of consecutive EXEC cycles.
    always @(negedge CLK) begin
        if (state == 3'd3) begin
            exec_run <= exec_run + 1;
        end else if (exec_run != 0) begin
            exec_last <= exec_run;
            exec_run  <= 0;
        end
    end

    function automatic logic [31:0] sext(input logic [15:0] v);
        return {{16{v[15]}}, v};
    endfunction

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic press(input logic [1:0] mask, input int hold);
        KEY = {2'b11, ~mask};
        repeat (hold) tick();
        KEY = 4'hF;
        repeat (12) tick();
    endtask

    task automatic model_clear();
        m_state = 0; m_a = 32'd0; m_b = 32'd0; m_op = 4'd0; m_res = 32'd0; m_fl = 3'd0;
    endtask

    task automatic model_enter();
        case (m_state)
            0: begin m_a = sext(SW[15:0]); m_state = 1; end
            1: begin m_b = sext(SW[15:0]); m_state = 2; end
            2: begin m_op = SW[3:0]; {m_res, m_fl} = alu_f(m_a, m_b, m_op); m_state = 4; end
            4: begin
                if (SW[16]) begin m_a = m_res; m_state = 1; end
                else m_state = 0;
            end
            default: m_state = 0;
        endcase
    endtask

    task automatic check_all(input string tag);
        logic [31:0] exp_disp;
        case (m_state)
            0, 1:    exp_disp = sext(SW[15:0]);
            2:       exp_disp = {28'd0, SW[3:0]};
            default: exp_disp = m_res;
        endcase
        check_eq({tag, "_state"}, 32'(state), 32'(m_state));
        check_eq({tag, "_portA"}, portA, m_a);
        check_eq({tag, "_portB"}, portB, m_b);
        check_eq({tag, "_aluop"}, 32'(aluop), 32'(m_op));
        check_eq({tag, "_flags"}, 32'(flags), 32'(m_fl));
        check_eq({tag, "_disp"}, disp_val, exp_disp);
    endtask

    initial begin
        int bad;
        int seen;
        RST = 1'b1; KEY = 4'hF; SW = 18'd0;
        model_clear();
        repeat (3) tick();
        RST = 1'b0;
        check_all("reset");
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (state != 3'd0) bad++;
        end
        check_eq("reset_quiet", 32'(bad), 32'd0);

        // Short bounce must not advance
        SW = 18'h00005;
        KEY = 4'hE;
        repeat (3) tick();
        KEY = 4'hF;
        repeat (12) tick();
        check_all("bounce");

        // 10-cycle press: advance lands on the 8th edge after the fall
        KEY = 4'hE;
        for (int n = 1; n <= 10; n++) begin
            tick();
            if (n == 7) check_eq("adv_early", 32'(state), 32'd0);
            if (n == 8) check_eq("adv_edge", 32'(state), 32'd1);
        end
        KEY = 4'hF;
        repeat (12) tick();
        model_enter();
        check_all("opA");

        SW = 18'h0FFFD; press(2'b01, 10); model_enter(); check_all("opB");
        check_eq("opB_const", portB, 32'hFFFFFFFD);
        SW = 18'h00000; press(2'b01, 10); model_enter(); check_all("add");
        check_eq("add_disp", disp_val, 32'h00000002);
        check_eq("add_flags", 32'(flags), 32'd0);
        check_eq("exec_len", 32'(exec_last), 32'd1);

        // Chain the result into operand A, then subtract 7
        SW = 18'h10000; press(2'b01, 9); model_enter(); check_all("chain");
        check_eq("chain_portA", portA, 32'h00000002);
        SW = 18'h00007; press(2'b01, 9); model_enter(); check_all("chainB");
        SW = 18'h00001; press(2'b01, 9); model_enter(); check_all("sub");
        check_eq("sub_disp", disp_val, 32'hFFFFFFFB);
        check_eq("sub_neg", 32'(flags[2]), 32'd1);

        // Clear and enter on the same cycle while in LOAD_OP
        SW = 18'h00000; press(2'b01, 9); model_enter();
        SW = 18'h01234; press(2'b01, 9); model_enter();
        SW = 18'h00F0F; press(2'b01, 9); model_enter(); check_all("pre_clr");
        SW = 18'h00003; press(2'b11, 9); model_clear(); check_all("clr_prio");

        // Reset on the EXEC cycle aborts the capture
        press(2'b01, 9); model_enter();
        SW = 18'h00004; press(2'b01, 9); model_enter();
        SW = 18'h00000;
        KEY = 4'hE;
        seen = 0;
        for (int n = 0; n < 14 && seen == 0; n++) begin
            tick();
            if (state == 3'd3) begin
                seen = 1;
                RST = 1'b1; KEY = 4'hF;
                tick();
                RST = 1'b0;
            end
        end
        KEY = 4'hF;
        check_eq("exec_seen", 32'(seen), 32'd1);
        model_clear();
        bad = 0;
        for (int i = 0; i < 12; i++) begin
            if (disp_val == 32'h00000007) bad++;
            tick();
        end
        check_eq("rst_exec_nodisp", 32'(bad), 32'd0);
        check_all("rst_exec");

        // Randomized sessions
        for (int t = 0; t < 40; t++) begin
            int r;
            r  = int'($urandom_range(0, 99));
            SW = 18'($urandom);
            if (r < 8) begin
                KEY = 4'hE;
                repeat (int'($urandom_range(1, 3))) tick();
                KEY = 4'hF;
                repeat (12) tick();
            end else if (r < 18) begin
                press(2'b10, int'($urandom_range(8, 12)));
                model_clear();
            end else begin
                press(2'b01, int'($urandom_range(8, 14)));
                model_enter();
            end
            check_all($sformatf("rnd%0d", t));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
